fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the number of instruction queue entries; the only legal value is 2.
REQ-003 CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  is the reset: asynchronous, active-low (0 = reset asserted).
REQ-005 IMEM_REQ  output  1  is a one-cycle fetch request strobe.
REQ-006 IMEM_ADDR  output  32  is the fetch address, equal to the PC register.
REQ-007 IMEM_ACK  input  1  marks the response cycle; it arrives at least 1 cycle after IMEM_REQ.
REQ-008 IMEM_RDATA  input  32  is the instruction word, valid when IMEM_ACK=1.
REQ-009 REDIRECT  input  1  is a branch/jump redirect from execute.
REQ-010 REDIRECT_PC  input  32  is the redirect target, valid when REDIRECT=1.
REQ-011 ID_STALL  input  1  means decode cannot accept an instruction this cycle.
REQ-012 IF_VALID  output  1  means the queue head is presented to decode.
REQ-013 IF_INSTR  output  32  is the queue-head instruction.
REQ-014 IF_PC  output  32  is the queue-head PC.

Function
REQ-015 The FSM SHALL have three states:
- IDLE: no request outstanding.
- WAIT: one request outstanding.
- DROP: one request outstanding whose response is discarded.
REQ-016 IMEM_REQ SHALL be combinational and SHALL be 1 only when state=IDLE, count<2 and REDIRECT=0.
- In that cycle: PC <= PC+4 (mod 2^32), tag <= PC, state <= WAIT.
REQ-017 At most one request SHALL be outstanding at any time.
REQ-018 In WAIT with IMEM_ACK=1 and REDIRECT=0, the FIFO SHALL push {tag, IMEM_RDATA} and the FSM SHALL go to IDLE.
REQ-019 In DROP with IMEM_ACK=1, the FIFO SHALL discard the response and the FSM SHALL go to IDLE.
REQ-020 IMEM_ACK in IDLE SHALL be ignored.
REQ-021 IF_VALID SHALL equal (count!=0); IF_INSTR and IF_PC SHALL show the head entry, or hold their last value when count=0.
REQ-022 Pop SHALL occur when IF_VALID=1, ID_STALL=0 and REDIRECT=0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance the head; the push pointer wraps modulo 2.
REQ-024 Push to a full queue SHALL NOT occur, because issue requires count<2; a full queue blocks issue until a pop.
REQ-025 REDIRECT=1 SHALL take priority over all push, pop and issue activity:
- count <= 0 and PC <= REDIRECT_PC.
- WAIT goes to DROP; DROP stays DROP; IDLE stays IDLE with no request that cycle.
REQ-026 REDIRECT coincident with IMEM_ACK in WAIT SHALL discard the response and go to IDLE.
REQ-027 Steady-state latency SHALL be REQ cycle + ACK cycle + 1, with the instruction on IF_* the cycle after ACK.
REQ-028 Throughput SHALL be one instruction per 2 cycles when IMEM_ACK arrives 1 cycle after IMEM_REQ.

Reset
REQ-029 While RESET=0, state SHALL be IDLE, PC=RESET_PC, count=0, FIFO pointers=0, IF_VALID=0, IF_INSTR=0, IF_PC=0, and IMEM_REQ=0.
REQ-030 Reset asserted while in WAIT or DROP SHALL abandon the outstanding request.
- A late IMEM_ACK after RESET returns to 1 is ignored, because the FSM is in IDLE.
REQ-031 The first IMEM_REQ SHALL assert in the first cycle after RESET deasserts, with IMEM_ADDR=RESET_PC.

Verification
REQ-032 Reset then 1-cycle-latency memory returning (addr^32'hA5A5_0000), ID_STALL=0 -> IF_PC sequence 0,4,8,... each matching its instruction, IF_VALID every other cycle.
REQ-033 ID_STALL=1 held for 10 cycles -> exactly 2 entries queued, IMEM_REQ stays 0, IF_PC frozen at 0; release -> PCs 0,4,8 delivered in order.
REQ-034 REDIRECT to 32'h0000_0100 while in WAIT -> queue empties, the next ACK is dropped, and the next IMEM_ADDR and first delivered IF_PC are 32'h0000_0100.
REQ-035 REDIRECT coincident with IMEM_ACK and with a pop -> no push, no pop, count=0, next request to REDIRECT_PC.
REQ-036 RESET pulsed low in WAIT, IMEM_ACK arrives 2 cycles after release -> ignored; first delivered IF_PC=RESET_PC, and there are no duplicate or missing PCs.
REQ-037 PC=32'hFFFF_FFFC fetched -> the next IMEM_ADDR is 32'h0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory and
// buffers returned words in a 2-entry queue feeding decode.
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   RESET        asynchronous active-low reset
//   IMEM_REQ     one-cycle fetch request strobe (combinational)
//   IMEM_ADDR    fetch address (the PC register)
//   IMEM_ACK     memory response strobe, at least one cycle after IMEM_REQ
//   IMEM_RDATA   instruction word, valid with IMEM_ACK
//   REDIRECT     branch/jump redirect from execute, flushes the queue
//   REDIRECT_PC  redirect target
//   ID_STALL     decode cannot accept an instruction this cycle
//   IF_VALID     queue head is presented to decode
//   IF_INSTR     queue-head instruction (holds last shown value when empty)
//   IF_PC        queue-head PC (holds last shown value when empty)
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        ID_STALL,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC
);

  localparam logic [1:0] Full = 2'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] last_instr_q, last_instr_d;

  logic        issue, push, pop, valid;
  logic [31:0] head_pc, head_instr;

  assign valid      = (count_q != 2'd0);
  assign head_pc    = fifo_pc_q[rd_ptr_q];
  assign head_instr = fifo_instr_q[rd_ptr_q];

  // Redirect overrides every issue/push/pop in the same cycle.
  assign issue = (state_q == StIdle) && (count_q != Full) && !REDIRECT;
  assign push  = (state_q == StWait) && IMEM_ACK && !REDIRECT;
  assign pop   = valid && !ID_STALL && !REDIRECT;

  // Gate with RESET so no strobe escapes while reset is held.
  assign IMEM_REQ  = RESET & issue;
  assign IMEM_ADDR = pc_q;
  assign IF_VALID  = valid;
  assign IF_PC     = valid ? head_pc : last_pc_q;
  assign IF_INSTR  = valid ? head_instr : last_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tag_d        = tag_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;

    // Remember what decode last saw so the outputs hold once the queue drains.
    if (valid) begin
      last_pc_d    = head_pc;
      last_instr_d = head_instr;
    end

    if (REDIRECT) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      pc_d     = REDIRECT_PC;
      // An outstanding fetch must still be drained; an ack this cycle finishes it.
      if (state_q != StIdle) begin
        state_d = IMEM_ACK ? StIdle : StDrop;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            tag_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = StWait;
          end
        end
        StWait, StDrop: begin
          if (IMEM_ACK) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (push) begin
        fifo_pc_d[wr_ptr_q]    = tag_q;
        fifo_instr_d[wr_ptr_q] = IMEM_RDATA;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      tag_q        <= RESET_PC;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_queue #(.RESET_PC(RstPc), .DEPTH(2)) dut (
    .CLK(clk), .RESET(rst_n),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr),
    .IMEM_ACK(imem_ack), .IMEM_RDATA(imem_rdata),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .ID_STALL(id_stall),
    .IF_VALID(if_valid), .IF_INSTR(if_instr), .IF_PC(if_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch pointer, one outstanding-request flag, a queue of
  // {pc, instr} entries and the last value decode was shown.
  logic [31:0] m_pc, m_tag, m_last_pc, m_last_instr;
  bit          m_out, m_drop;
  logic [63:0] m_q[$];

  // Memory responder (stimulus): answers each request after mem_lat cycles.
  bit          r_pend;
  logic [31:0] r_addr;
  int          r_cnt;
  int          mem_lat = 1;
  bit          stale_ack;
  logic        cap_req;
  logic [31:0] cap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit exp_req();
    return (rst_n === 1'b1) && !m_out && (m_q.size() < 2) && (redirect !== 1'b1);
  endfunction

  function automatic logic [31:0] exp_pc();
    if (m_q.size() != 0) return m_q[0][63:32];
    return m_last_pc;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_q.size() != 0) return m_q[0][31:0];
    return m_last_instr;
  endfunction

  task automatic model_reset();
    m_pc = RstPc; m_tag = RstPc; m_out = 0; m_drop = 0;
    m_q.delete(); m_last_pc = '0; m_last_instr = '0;
  endtask

  // Apply inputs for one cycle (after the falling edge) and let them settle.
  task automatic drive(input bit stall, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    id_stall = stall; redirect = redir; redirect_pc = rpc;
    if (r_pend && r_cnt == 0) begin
      imem_ack = 1'b1; imem_rdata = mem_word(r_addr);
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom();
    end
    #1;
    cap_req = imem_req; cap_addr = imem_addr;
  endtask

  // Advance model and responder across the rising edge.
  task automatic edge_update();
    bit issue;
    issue = exp_req();
    @(posedge clk);
    if (m_q.size() != 0) begin
      m_last_pc = m_q[0][63:32]; m_last_instr = m_q[0][31:0];
    end
    if (redirect) begin
      if (imem_ack && m_out) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      if (m_q.size() != 0 && !id_stall) void'(m_q.pop_front());
      if (imem_ack && m_out) begin
        if (!m_drop) m_q.push_back({m_tag, imem_rdata});
        m_out = 0; m_drop = 0;
      end
      if (issue) begin m_tag = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
    end
    if (imem_ack && !stale_ack) r_pend = 0;
    else if (r_pend && r_cnt > 0) r_cnt--;
    if (cap_req) begin r_pend = 1; r_addr = cap_addr; r_cnt = mem_lat - 1; end
    stale_ack = 0;
  endtask

  task automatic do_reset(input bit stall);
    @(negedge clk);
    rst_n = 1'b0; id_stall = stall; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    model_reset(); r_pend = 0; stale_ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cap_req = imem_req; cap_addr = imem_addr;
    edge_update();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    model_reset(); r_pend = 0; stale_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got=%h want=0", if_instr); end
    checks++; if (imem_addr !== RstPc) begin errors++; $display("FAIL rst_addr got=%h want=%h", imem_addr, RstPc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cap_req = imem_req; cap_addr = imem_addr;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b want=1", imem_req); end
    checks++; if (imem_addr !== RstPc) begin errors++; $display("FAIL first_addr got=%h want=%h", imem_addr, RstPc); end
    edge_update();
  endtask

  task automatic test_stream();
    logic [31:0] obs_pc[$];
    logic [31:0] obs_in[$];
    mem_lat = 1;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0, '0);
      checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL stream_req c=%0d got=%b want=%b", c, imem_req, exp_req()); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL stream_addr c=%0d got=%h want=%h", c, imem_addr, m_pc); end
      checks++; if (if_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, if_valid, m_q.size() != 0); end
      checks++; if (if_pc !== exp_pc()) begin errors++; $display("FAIL stream_pc c=%0d got=%h want=%h", c, if_pc, exp_pc()); end
      checks++; if (if_instr !== exp_instr()) begin errors++; $display("FAIL stream_instr c=%0d got=%h want=%h", c, if_instr, exp_instr()); end
      if (if_valid === 1'b1) begin obs_pc.push_back(if_pc); obs_in.push_back(if_instr); end
      edge_update();
    end
    // One instruction every two cycles, in PC order.
    checks++; if (obs_pc.size() < 9) begin errors++; $display("FAIL stream_count got=%0d want>=9", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== RstPc + 32'(4 * i) || obs_in[i] !== mem_word(RstPc + 32'(4 * i))) begin
        errors++; $display("FAIL stream_seq i=%0d got=%h/%h want=%h", i, obs_pc[i], obs_in[i], RstPc + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] obs_pc[$];
    int          obs_cyc[$];
    mem_lat = 1;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, '0);
      if (c >= 3) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c=%0d got=%b want=0", c, imem_req); end
        checks++; if (if_pc !== RstPc) begin errors++; $display("FAIL stall_pc c=%0d got=%h want=%h", c, if_pc, RstPc); end
      end
      edge_update();
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, '0);
      if (if_valid === 1'b1) begin obs_pc.push_back(if_pc); obs_cyc.push_back(c); end
      edge_update();
    end
    checks++;
    if (obs_pc.size() < 3) begin
      errors++; $display("FAIL stall_count got=%0d want>=3", obs_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_pc[i] !== RstPc + 32'(4 * i)) begin errors++; $display("FAIL stall_seq i=%0d got=%h want=%h", i, obs_pc[i], RstPc + 32'(4 * i)); end
      end
      // Two queued entries drain on consecutive cycles.
      checks++; if (obs_cyc[0] != 0 || obs_cyc[1] != 1) begin errors++; $display("FAIL stall_queued got=%0d,%0d want=0,1", obs_cyc[0], obs_cyc[1]); end
    end
  endtask

  task automatic test_redirect_wait();
    bit seen_req = 0, seen_valid = 0;
    mem_lat = 3;
    do_reset(1'b0);
    drive(1'b0, 1'b1, 32'h0000_0100);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req got=%b want=0", imem_req); end
    edge_update();
    for (int j = 0; j < 20; j++) begin
      drive(1'b0, 1'b0, '0);
      if (!seen_valid) begin
        checks++; if (if_valid === 1'b1 && if_pc !== 32'h100) begin errors++; $display("FAIL rdw_first_pc got=%h want=00000100", if_pc); end
      end
      if (if_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        checks++; if (if_instr !== mem_word(32'h100)) begin errors++; $display("FAIL rdw_first_instr got=%h want=%h", if_instr, mem_word(32'h100)); end
      end
      if (imem_req === 1'b1 && !seen_req) begin
        seen_req = 1;
        checks++; if (imem_addr !== 32'h100 || j != 2) begin errors++; $display("FAIL rdw_next_req got=%h@%0d want=00000100@2", imem_addr, j); end
      end
      edge_update();
    end
    checks++; if (!seen_req || !seen_valid) begin errors++; $display("FAIL rdw_timeout got=%b%b want=11", seen_req, seen_valid); end
  endtask

  task automatic test_redirect_ack_pop();
    bit seen_valid = 0;
    mem_lat = 1;
    do_reset(1'b1);
    drive(1'b1, 1'b0, '0); edge_update();
    drive(1'b1, 1'b0, '0); edge_update();
    drive(1'b0, 1'b1, 32'h0000_0200);
    checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rap_pre got=%b%b want=10", if_valid, imem_req); end
    edge_update();
    drive(1'b0, 1'b0, '0);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rap_count got=%b want=0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rap_next got=%b/%h want=1/00000200", imem_req, imem_addr); end
    edge_update();
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, 1'b0, '0);
      if (if_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        checks++; if (if_pc !== 32'h200) begin errors++; $display("FAIL rap_first_pc got=%h want=00000200", if_pc); end
      end
      edge_update();
    end
    checks++; if (!seen_valid) begin errors++; $display("FAIL rap_timeout got=0 want=1"); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] obs_pc[$];
    mem_lat = 1;
    do_reset(1'b0);
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; model_reset(); r_pend = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale_ack = 1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    cap_req = imem_req; cap_addr = imem_addr;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RstPc) begin errors++; $display("FAIL riw_req got=%b/%h want=1/%h", imem_req, imem_addr, RstPc); end
    edge_update();
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, '0);
      if (if_valid === 1'b1) obs_pc.push_back(if_pc);
      edge_update();
    end
    checks++; if (obs_pc.size() < 4) begin errors++; $display("FAIL riw_count got=%0d want>=4", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      checks++; if (obs_pc[i] !== RstPc + 32'(4 * i)) begin errors++; $display("FAIL riw_seq i=%0d got=%h want=%h", i, obs_pc[i], RstPc + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    bit seen_req = 0, seen_valid = 0;
    mem_lat = 1;
    do_reset(1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFFC); edge_update();
    drive(1'b0, 1'b0, '0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%b/%h want=1/fffffffc", imem_req, imem_addr); end
    edge_update();
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, 1'b0, '0);
      if (imem_req === 1'b1 && !seen_req) begin
        seen_req = 1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h want=00000000", imem_addr); end
      end
      if (if_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h want=fffffffc", if_pc); end
      end
      edge_update();
    end
    checks++; if (!seen_req || !seen_valid) begin errors++; $display("FAIL wrap_timeout got=%b%b want=11", seen_req, seen_valid); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit          st, rd;
    do_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      mem_lat = $urandom_range(1, 3);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom();
      rpc[1:0] = 2'b00;
      drive(st, rd, rpc);
      checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, imem_req, exp_req()); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr, m_pc); end
      checks++; if (if_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, if_valid, m_q.size() != 0); end
      checks++; if (if_pc !== exp_pc()) begin errors++; $display("FAIL rnd_pc c=%0d got=%h want=%h", c, if_pc, exp_pc()); end
      checks++; if (if_instr !== exp_instr()) begin errors++; $display("FAIL rnd_instr c=%0d got=%h want=%h", c, if_instr, exp_instr()); end
      edge_update();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
